// File: rtl/movement_pkg.sv
// movement_pkg: movement codes, heading encoding and executor states shared with the navigation FSM
package movement_pkg;
   localparam logic [3:0] MOV_NONE = 4'b0000;
   localparam logic [3:0] MOV_N    = 4'b0001;
   localparam logic [3:0] MOV_E    = 4'b0100;
   localparam logic [3:0] MOV_S    = 4'b0010;
   localparam logic [3:0] MOV_W    = 4'b0011;
   localparam logic [1:0] HDG_N = 2'd0;
   localparam logic [1:0] HDG_E = 2'd1;
   localparam logic [1:0] HDG_S = 2'd2;
   localparam logic [1:0] HDG_W = 2'd3;
   typedef enum logic [2:0] {IDLE, TURN_R, TURN_L, FWD, DONE} exec_state_t;
   function automatic logic code_valid(input logic [3:0] c);
      return c == MOV_N || c == MOV_E || c == MOV_S || c == MOV_W;
   endfunction
   function automatic logic [1:0] code_heading(input logic [3:0] c);
      return c == MOV_E ? HDG_E : c == MOV_S ? HDG_S : c == MOV_W ? HDG_W : HDG_N;
   endfunction
endpackage

// File: rtl/movement_executor_if.sv
// movement_executor_if: command code in, motor pins and status out
interface movement_executor_if;
   logic [3:0] movement_sel;
   logic       motor_l_en;
   logic       motor_l_dir;
   logic       motor_r_en;
   logic       motor_r_dir;
   logic [1:0] heading;
   logic       busy;
   logic       cmd_ready;
   logic       done;
   logic       cmd_err;
   modport master (output movement_sel, input motor_l_en, motor_l_dir, motor_r_en, motor_r_dir, heading, busy, cmd_ready, done, cmd_err);
   modport slave (input movement_sel, output motor_l_en, motor_l_dir, motor_r_en, motor_r_dir, heading, busy, cmd_ready, done, cmd_err);
endinterface

// File: rtl/movement_executor_move_timer.sv
// move_timer: clearable up-counter flagging when it sits on the terminal value
module move_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [CNT_W-1:0] term,
   output logic             tc
);
   logic [CNT_W-1:0] cnt;
   // count every cycle, restart from zero on clear
   always_ff @(posedge clk)
      cnt <= (rst || clr) ? '0 : cnt + 1'b1;
   assign tc = cnt == term;
endmodule

// File: rtl/movement_executor.sv
// movement_executor: turns to the commanded heading by the shortest path, then drives forward
module movement_executor
   import movement_pkg::*;
#(
   parameter int TURN_CYCLES = 16,
   parameter int MOVE_CYCLES = 32,
   parameter int CNT_W       = 16
) (
   input logic clk,
   input logic rst,
   movement_executor_if.slave bus
);
   exec_state_t state;
   logic [1:0]  heading;
   logic [1:0]  turns_left;
   logic [1:0]  diff;
   logic        cmd_err;
   logic        tc;
   assign diff = code_heading(bus.movement_sel) - heading;
   move_timer #(.CNT_W(CNT_W)) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (state == IDLE || state == DONE || tc),
      .term(state == FWD ? CNT_W'(MOVE_CYCLES - 1) : CNT_W'(TURN_CYCLES - 1)),
      .tc  (tc)
   );
   // command sequencing, heading tracking and the invalid-code flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         heading    <= HDG_N;
         turns_left <= 2'd0;
         cmd_err    <= 1'b0;
      end else begin
         cmd_err <= 1'b0;
         case (state)
            IDLE: begin
               cmd_err <= bus.movement_sel != MOV_NONE && !code_valid(bus.movement_sel);
               if (code_valid(bus.movement_sel)) begin
                  state      <= diff == 2'd0 ? FWD : diff == 2'd3 ? TURN_L : TURN_R;
                  turns_left <= diff == 2'd2 ? 2'd2 : diff == 2'd0 ? 2'd0 : 2'd1;
               end
            end
            TURN_R, TURN_L: if (tc) begin
               heading    <= state == TURN_R ? heading + 2'd1 : heading - 2'd1;
               turns_left <= turns_left - 2'd1;
               if (turns_left == 2'd1) state <= FWD;
            end
            FWD: if (tc) state <= DONE;
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.motor_l_en  = state == TURN_R || state == TURN_L || state == FWD;
   assign bus.motor_r_en  = state == TURN_R || state == TURN_L || state == FWD;
   assign bus.motor_l_dir = state == TURN_R || state == FWD;
   assign bus.motor_r_dir = state == TURN_L || state == FWD;
   assign bus.heading     = heading;
   assign bus.busy        = state != IDLE;
   assign bus.cmd_ready   = state == IDLE;
   assign bus.done        = state == DONE;
   assign bus.cmd_err     = cmd_err;
endmodule

// File: tb/tb_movement_executor.sv
// tb_movement_executor: random and directed moves checked cycle by cycle against a heading/turn model
module tb_movement_executor;
   localparam int T = 16;
   localparam int M = 32;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   mh = 0;
   logic [9:0] obs;
   logic [9:0] e;
   always #5 clk = ~clk;
   movement_executor_if bus();
   movement_executor #(.TURN_CYCLES(T), .MOVE_CYCLES(M), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   assign obs = {bus.motor_l_en, bus.motor_l_dir, bus.motor_r_en, bus.motor_r_dir, bus.heading,
                 bus.busy, bus.done, bus.cmd_ready, bus.cmd_err};

   function automatic logic [9:0] vec(input logic [3:0] mot, input int h, input logic b, input logic d,
                                      input logic r, input logic er);
      return {mot, 2'(h), b, d, r, er};
   endfunction

   function automatic int tgt_of(input logic [3:0] c);
      return c == 4'b0001 ? 0 : c == 4'b0100 ? 1 : c == 4'b0010 ? 2 : 3;
   endfunction

   function automatic logic [3:0] code_of(input int h);
      return h == 0 ? 4'b0001 : h == 1 ? 4'b0100 : h == 2 ? 4'b0010 : 4'b0011;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.movement_sel = 4'b0000;
      step();
      step();
      e = vec(4'b0000, 0, 0, 0, 1, 0);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset obs=%b exp=%b", obs, e);
      end
      rst = 1'b0;
      mh = 0;
      step();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_idle obs=%b exp=%b", obs, e);
      end
   endtask

   task automatic run_move(input logic [3:0] code, input bit hold, input string name);
      int tgt, d, n, r, len;
      tgt = tgt_of(code);
      d = (tgt - mh + 4) % 4;
      n = (d == 3) ? 1 : d;
      r = (d == 3) ? -1 : 1;
      len = n * T + M + 1;
      bus.movement_sel = code;
      step();
      for (int k = 1; k <= len; k++) begin
         if (k <= n * T) e = vec(r == 1 ? 4'b1110 : 4'b1011, (mh + r * ((k - 1) / T) + 4) % 4, 1, 0, 0, 0);
         else if (k <= n * T + M) e = vec(4'b1111, tgt, 1, 0, 0, 0);
         else e = vec(4'b0000, tgt, 1, 1, 0, 0);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s cycle %0d obs=%b exp=%b", name, k, obs, e);
         end
         if (!hold) bus.movement_sel = (k == len) ? 4'b0000 : 4'($urandom);
         step();
      end
      mh = tgt;
      e = vec(4'b0000, mh, 0, 0, 1, 0);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL %s idle obs=%b exp=%b", name, obs, e);
      end
   endtask

   task automatic test_straight_back_to_back();
      test_reset();
      run_move(4'b0001, 1'b1, "straight_held");
      run_move(4'b0001, 1'b0, "straight_reissue");
   endtask

   task automatic test_turns();
      test_reset();
      run_move(4'b0100, 1'b0, "turn_right");
      test_reset();
      run_move(4'b0011, 1'b0, "turn_left_wrap");
      test_reset();
      run_move(4'b0100, 1'b0, "to_east");
      run_move(4'b0011, 1'b0, "u_turn");
   endtask

   task automatic test_cmd_err();
      logic [3:0] bad;
      bad = 4'($urandom_range(5, 15));
      bus.movement_sel = bad;
      step();
      e = vec(4'b0000, mh, 0, 0, 1, 1);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL cmd_err_set code=%b obs=%b exp=%b", bad, obs, e);
      end
      step();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL cmd_err_held code=%b obs=%b exp=%b", bad, obs, e);
      end
      bus.movement_sel = 4'b0000;
      step();
      e = vec(4'b0000, mh, 0, 0, 1, 0);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL cmd_err_clear obs=%b exp=%b", obs, e);
      end
   endtask

   task automatic test_reset_mid_turn();
      bus.movement_sel = code_of((mh + 1) % 4);
      step();
      for (int k = 1; k < 8; k++) step();
      e = vec(4'b1110, mh, 1, 0, 0, 0);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL mid_turn_cycle8 obs=%b exp=%b", obs, e);
      end
      rst = 1'b1;
      bus.movement_sel = 4'b0000;
      step();
      rst = 1'b0;
      mh = 0;
      e = vec(4'b0000, 0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid_turn cycle %0d obs=%b exp=%b", k, obs, e);
         end
         step();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 3) == 0) test_cmd_err();
         run_move(code_of(int'($urandom_range(0, 3))), 1'($urandom_range(0, 1)), $sformatf("random%0d", i));
      end
   endtask

   initial begin
      bus.movement_sel = 4'b0000;
      test_reset();
      test_straight_back_to_back();
      test_turns();
      test_cmd_err();
      run_move(4'b0010, 1'b0, "pre_reset_move");
      test_reset_mid_turn();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/movement_executor.md
Name: movement_executor

Overview:
- Consumes the 4-bit absolute-direction movement code from the maze-solving FSM.
- Drives the two wheel motors to execute the code: first rotates the robot to the commanded heading by the shortest path, then drives forward for a fixed time.
- Tracks the robot heading and reports busy/done/error status.
- Sits between the navigation FSM and the motor driver pins.

Parameters:
- TURN_CYCLES, 16, clock cycles per 90-degree in-place rotation (>=1)
- MOVE_CYCLES, 32, clock cycles of forward drive per move (>=1)
- CNT_W, 16, timer width; must hold max(TURN_CYCLES, MOVE_CYCLES)-1

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- movement_sel  in  4  command code: 0000 none, 0001 N, 0100 E, 0010 S, 0011 W
- motor_l_en  out  1  left motor enable
- motor_l_dir  out  1  left motor direction, 1=forward 0=reverse
- motor_r_en  out  1  right motor enable
- motor_r_dir  out  1  right motor direction, 1=forward 0=reverse
- heading  out  2  current heading: 0=N 1=E 2=S 3=W
- busy  out  1  command in progress
- cmd_ready  out  1  idle, will sample movement_sel this cycle
- done  out  1  one-cycle pulse at move completion
- cmd_err  out  1  registered flag for an invalid code seen while idle

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- On reset, at the next edge:
  - state=IDLE, heading=0 (N), timer=0, turns_left=0.
  - All motor outputs=0, busy=0, done=0, cmd_err=0, cmd_ready=1.
- Reset mid-operation has the same effect; there is no partial completion and no done pulse.
- States: IDLE, TURN_R, TURN_L, FWD, DONE. Outputs are Moore-decoded from registered state; only cmd_err is a registered function of the input.
- IDLE: cmd_ready=1, motors off. movement_sel is sampled every cycle.
  - 0000: stay in IDLE.
  - Valid code: latch target; diff = (target - heading) mod 4; timer=0.
    - diff 0 -> FWD
    - diff 1 -> TURN_R, turns_left=1
    - diff 2 -> TURN_R, turns_left=2 (180 degrees is always turned right)
    - diff 3 -> TURN_L, turns_left=1
  - Any other code: stay in IDLE; cmd_err=1 on the next cycle. cmd_err re-evaluates every cycle, so it stays high while the invalid code is held.
- TURN_R: left motor forward, right motor reverse (both enabled).
  - When timer==TURN_CYCLES-1: heading+=1 mod 4, turns_left-=1, timer=0.
  - If turns_left reaches 0 -> FWD, else remain in TURN_R.
  - Otherwise timer+=1.
- TURN_L: mirror of TURN_R (left reverse, right forward); heading-=1 mod 4.
- FWD: both motors enabled, forward. When timer==MOVE_CYCLES-1 -> DONE; else timer+=1.
- DONE: motors off, done=1 for exactly this cycle, busy=1; next state is IDLE.
- busy=1 in every state except IDLE.
- While busy, movement_sel is ignored; the latched target governs. A changed code is sampled only on return to IDLE.
- Held code: a held valid code re-issues a new move from IDLE (straight, diff 0) back-to-back. There is exactly one IDLE cycle between consecutive commands.
- Latency: accept edge in cycle 0, then turns x TURN_CYCLES turn cycles, then MOVE_CYCLES forward cycles. done is high in cycle (turns x TURN_CYCLES + MOVE_CYCLES + 1).
- Heading updates exactly at the end of each 90-degree step; heading wraps 3->0 and 0->3.
- Timer arithmetic is CNT_W bits unsigned; heading arithmetic is 2 bits, modulo 4 by truncation.

Decomposition:
- Shared package movement_pkg:
  - movement code constants (MOV_NONE, MOV_N, MOV_E, MOV_S, MOV_W)
  - heading encoding constants
  - executor state encoding
- The navigation FSM and this block both import movement_pkg.
- One natural sub-module, move_timer: a load/clear terminal-count counter with a parameterised terminal value and a tc output, reused for turn and move timing.

Test Plan:
1. Reset, hold 0001 with heading N -> FWD cycles 1-32 with motors l_en=r_en=1 and both dirs=1; done=1 at cycle 33; heading stays 0; IDLE at 34 re-accepts.
2. Reset, pulse 0100 for one cycle -> TURN_R cycles 1-16 (l_dir=1, r_dir=0); heading=1 from cycle 17; FWD 17-48; done at 49.
3. Reset, apply 0011 -> TURN_L 16 cycles; heading=3 after wrap from 0; done at 49.
4. From heading E, apply 0011 -> two TURN_R steps over 32 cycles; heading 2 at cycle 17, 3 at cycle 33; done at 65.
5. In IDLE, apply 1111 -> cmd_err=1 the following cycle, motors stay 0, busy=0. Then apply 0000 -> cmd_err=0 the next cycle.
6. Assert rst at cycle 8 of a turn -> next cycle motors all 0, heading=0, busy=0, no done. Separately, change movement_sel during FWD -> the move completes per the latched target.
